// File: rtl/reg_file.sv
// reg_file: 2R/1W architectural register file with r0 hardwired to zero,
// optional write-through bypass, unbypassed debug port and saturating write counter.
module reg_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [ADDR_W-1:0] dbg_a,
    output logic [DATA_W-1:0] dbg_d,
    output logic [15:0]       wr_count
);
    localparam int DEPTH = 2 ** ADDR_W;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [15:0]       cnt_q, cnt_d;
    logic              wr_en;
    assign wr_en = we && (wa != '0) && !reset;
    always_comb begin
        cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 16'd1;
        // reset gating keeps a pending bypass from leaking through while reset is held
        rd1   = (reset || ra1 == '0) ? '0 : (BYPASS != 0 && wr_en && ra1 == wa) ? wd : mem_q[ra1];
        rd2   = (reset || ra2 == '0) ? '0 : (BYPASS != 0 && wr_en && ra2 == wa) ? wd : mem_q[ra2];
        dbg_d = (reset || dbg_a == '0) ? '0 : mem_q[dbg_a];
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            cnt_q <= '0;
        end else if (wr_en) begin
            mem_q[wa] <= wd;
            cnt_q     <= cnt_d;
        end
    end
    assign wr_count = cnt_q;
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: randomized and directed checks of reg_file (bypass on and off) against an array model.
`timescale 1ns/1ps
module tb_reg_file;
    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  ra1, ra2, wa, dbg_a;
    logic        we;
    logic [31:0] wd;
    logic [31:0] rd1_b, rd2_b, dbg_b, rd1_n, rd2_n, dbg_n;
    logic [15:0] cnt_b, cnt_n;
    logic [31:0] ref_mem [32];
    int          ref_cnt;
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    reg_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) u_byp (
        .clk(clk), .reset(reset), .ra1(ra1), .ra2(ra2), .rd1(rd1_b), .rd2(rd2_b),
        .we(we), .wa(wa), .wd(wd), .dbg_a(dbg_a), .dbg_d(dbg_b), .wr_count(cnt_b));
    reg_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) u_nob (
        .clk(clk), .reset(reset), .ra1(ra1), .ra2(ra2), .rd1(rd1_n), .rd2(rd2_n),
        .we(we), .wa(wa), .wd(wd), .dbg_a(dbg_a), .dbg_d(dbg_n), .wr_count(cnt_n));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
        if (reset || a == 0) return 32'd0;
        if (byp && we && wa != 0 && wa == a) return wd;
        return ref_mem[a];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) ref_mem[i] = 32'd0;
        ref_cnt = 0;
    endtask

    task automatic check_all();
        chk("rd1_byp", rd1_b, exp_rd(ra1, 1'b1));
        chk("rd2_byp", rd2_b, exp_rd(ra2, 1'b1));
        chk("rd1_nob", rd1_n, exp_rd(ra1, 1'b0));
        chk("rd2_nob", rd2_n, exp_rd(ra2, 1'b0));
        chk("dbg_byp", dbg_b, exp_rd(dbg_a, 1'b0));
        chk("dbg_nob", dbg_n, exp_rd(dbg_a, 1'b0));
        chk("cnt_byp", {16'd0, cnt_b}, ref_cnt);
        chk("cnt_nob", {16'd0, cnt_n}, ref_cnt);
    endtask

    task automatic drive(input logic w, input logic [4:0] a, input logic [31:0] d,
                         input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] da);
        we = w; wa = a; wd = d; ra1 = r1; ra2 = r2; dbg_a = da;
    endtask

    task automatic edge_update();
        @(posedge clk);
        if (!reset && we && wa != 0) begin
            ref_mem[wa] = wd;
            if (ref_cnt < 65535) ref_cnt++;
        end
        #1;
    endtask

    task automatic cycle();
        #3 check_all();
        edge_update();
    endtask

    initial begin
        reset = 1'b1;
        model_clear();
        drive(1'b1, 5'd4, 32'hCAFEF00D, 5'd4, 5'd4, 5'd4);
        @(posedge clk); #1;
        check_all();
        @(posedge clk); #1;
        reset = 1'b0;

        // reset pulse between edges
        drive(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5, 5'd5);
        cycle();
        drive(1'b0, 5'd0, 32'd0, 5'd5, 5'd5, 5'd5);
        #2;
        chk("r5_before_rst", rd1_b, 32'hDEADBEEF);
        reset = 1'b1;
        model_clear();
        #0.1;
        chk("rst_rd1_imm", rd1_b, 32'd0);
        chk("rst_cnt", {16'd0, cnt_b}, 32'd0);
        for (int i = 0; i < 32; i++) begin
            dbg_a = 5'(i);
            #0.05;
            chk("rst_dbg", dbg_b, 32'd0);
        end
        #1.25 reset = 1'b0;
        edge_update();

        // reset collides with a write
        ref_mem[3] = 32'd0;
        drive(1'b1, 5'd3, 32'h11111111, 5'd3, 5'd3, 5'd3);
        cycle();
        drive(1'b1, 5'd9, 32'h12345678, 5'd9, 5'd9, 5'd9);
        #2 reset = 1'b1;
        model_clear();
        #1 check_all();
        edge_update();
        reset = 1'b0;
        we = 1'b0;
        #1 check_all();
        chk("coll_r9", dbg_b, 32'd0);
        edge_update();

        // basic write/read
        drive(1'b1, 5'd3, 32'd15, 5'd0, 5'd0, 5'd0);
        cycle();
        drive(1'b1, 5'd4, 32'd7, 5'd3, 5'd0, 5'd3);
        cycle();
        drive(1'b0, 5'd0, 32'd0, 5'd3, 5'd4, 5'd4);
        #3;
        chk("basic_rd1", rd1_b, 32'd15);
        chk("basic_rd2", rd2_b, 32'd7);
        chk("basic_cnt", {16'd0, cnt_b}, 32'd2);
        cycle();

        // r0 hardwired
        drive(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd0);
        cycle();
        drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0);
        cycle();

        // bypass on/off
        drive(1'b1, 5'd7, 32'd10, 5'd1, 5'd2, 5'd3);
        cycle();
        drive(1'b1, 5'd7, 32'h00AA00FF, 5'd7, 5'd7, 5'd7);
        #3;
        chk("byp_rd1", rd1_b, 32'h00AA00FF);
        chk("nob_rd2", rd2_n, 32'd10);
        chk("byp_dbg_pre", dbg_b, 32'd10);
        cycle();
        drive(1'b0, 5'd0, 32'd0, 5'd7, 5'd7, 5'd7);
        cycle();

        // random traffic
        for (int i = 0; i < 400; i++) begin
            logic [4:0] a;
            a = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
            drive(1'($urandom), a, $urandom,
                  $urandom_range(0, 2) == 0 ? a : 5'($urandom),
                  $urandom_range(0, 2) == 0 ? a : 5'($urandom),
                  5'($urandom));
            cycle();
        end

        // counter saturation
        for (int i = 0; i < 65536; i++) begin
            drive(1'b1, 5'd1, $urandom, 5'd1, 5'd2, 5'd1);
            edge_update();
        end
        drive(1'b0, 5'd0, 32'd0, 5'd1, 5'd2, 5'd1);
        #3;
        chk("sat_cnt", {16'd0, cnt_b}, 32'h0000FFFF);
        cycle();
        drive(1'b1, 5'd6, 32'h0BADCAFE, 5'd6, 5'd1, 5'd6);
        cycle();
        drive(1'b0, 5'd0, 32'd0, 5'd6, 5'd1, 5'd6);
        cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
